// File: rtl/ifetch_stage.sv
`default_nettype none
// ============================================================================
// ifetch_stage : RV32 fetch front end (PC, imem request, fetch queue to decode)
// Optional feature macro: IFETCH_PERF_CNT_EN (adds fetch_count)  | Rev 1.0
// ============================================================================
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  localparam int              PW      = $clog2(FQ_DEPTH);
  localparam logic [31:0]     C_NOP   = 32'h0000_0013;
  localparam logic [PW+1:0]   C_DEPTH = (PW+2)'(FQ_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q [FQ_DEPTH];
  logic [31:0]   instr_d [FQ_DEPTH];
  logic [31:0]   epc_q   [FQ_DEPTH];
  logic [31:0]   epc_d   [FQ_DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]   count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   req_pc_q, req_pc_d;

  logic          pop;
  logic          push;
  logic [PW+1:0] credits_used;

  always_comb begin
    id_valid     = !reset && !redirect && (count_q != '0);
    pop          = id_valid && id_ready;
    push         = inflight_q && !redirect;
    // A pop this cycle frees its slot for a request issued in the same cycle.
    credits_used = {1'b0, count_q} + {{(PW+1){1'b0}}, inflight_q}
                 - {{(PW+1){1'b0}}, pop};
    imem_req     = !reset && !redirect && (credits_used < C_DEPTH);
    imem_addr    = pc_q;
    id_instr     = instr_q[rd_q];
    id_pc        = epc_q[rd_q];
  end

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    epc_d      = epc_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    req_pc_d   = req_pc_q;
    if (redirect) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      rd_d       = '0;
      wr_d       = '0;
      count_d    = '0;
      inflight_d = 1'b0;
    end else begin
      if (push) begin
        instr_d[wr_q] = imem_rdata;
        epc_d[wr_q]   = req_pc_q;
        wr_d          = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      if (imem_req) begin
        pc_d       = pc_q + 32'd4;
        inflight_d = 1'b1;
        req_pc_d   = pc_q;
      end else begin
        inflight_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      req_pc_q   <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        instr_q[i] <= C_NOP;
        epc_q[i]   <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      epc_q      <= epc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      req_pc_q   <= req_pc_d;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q + {31'd0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_stage.sv
`default_nettype none
// ============================================================================
// tb_ifetch_stage : randomized bench with a queue-based fetch reference model
// Rev 1.0
// ============================================================================
module tb_ifetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset, redirect, id_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, id_valid;
  logic [31:0] imem_addr, imem_rdata, id_instr, id_pc;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  ifetch_stage #(.RESET_PC(RESET_PC), .FQ_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_ready   (id_ready)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_count(fetch_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Synchronous instruction memory with one-cycle read latency.
  always @(posedge clk) imem_rdata <= imem_req ? memf(imem_addr) : 32'hDEAD_BEEF;

  int total = 0;
  int bad   = 0;

  // Reference model: ordered list of PCs waiting for decode, plus one read in flight.
  logic [31:0] m_q[$];
  logic        m_infl;
  logic [31:0] m_infl_pc, m_pc, m_cnt;
  logic        e_req, e_valid, e_pop;
  logic [31:0] e_addr, e_pc, e_instr, e_cnt;

  task automatic cyc(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    reset = r; redirect = rd; redirect_pc = rpc; id_ready = rdy;
    #1;
    e_valid = !r && !rd && (m_q.size() != 0);
    e_pc    = e_valid ? m_q[0] : 32'h0;
    e_instr = memf(e_pc);
    e_pop   = e_valid && rdy;
    e_req   = !r && !rd && ((int'(m_q.size()) + int'(m_infl) - int'(e_pop)) < DEPTH);
    e_addr  = m_pc;
    e_cnt   = m_cnt;
    if (r) begin
      m_q.delete(); m_infl = 1'b0; m_pc = RESET_PC; m_cnt = 32'h0;
    end else if (rd) begin
      m_q.delete(); m_infl = 1'b0; m_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (e_pop) begin void'(m_q.pop_front()); m_cnt = m_cnt + 1; end
      if (m_infl) m_q.push_back(m_infl_pc);
      if (e_req) begin m_infl = 1'b1; m_infl_pc = m_pc; m_pc = m_pc + 32'd4; end
      else m_infl = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1);
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
      total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
      total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC); end
      total++; if (id_instr !== 32'h0000_0013) begin bad++; $display("FAIL reset_instr got=%h exp=00000013", id_instr); end
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 14; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      total++; if (imem_req !== e_req) begin bad++; $display("FAIL stream_req c%0d got=%b exp=%b", i, imem_req, e_req); end
      total++; if (imem_addr !== e_addr) begin bad++; $display("FAIL stream_addr c%0d got=%h exp=%h", i, imem_addr, e_addr); end
      total++; if (id_valid !== e_valid) begin bad++; $display("FAIL stream_valid c%0d got=%b exp=%b", i, id_valid, e_valid); end
      if (e_valid) begin
        total++; if (id_pc !== e_pc || id_instr !== e_instr) begin bad++; $display("FAIL stream_head c%0d got=%h/%h exp=%h/%h", i, id_pc, id_instr, e_pc, e_instr); end
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 14; i++) begin
      cyc(1'b0, 1'b0, 32'h0, i >= 6);
      total++; if (imem_req !== e_req) begin bad++; $display("FAIL stall_req c%0d got=%b exp=%b", i, imem_req, e_req); end
      total++; if (imem_addr !== e_addr) begin bad++; $display("FAIL stall_addr c%0d got=%h exp=%h", i, imem_addr, e_addr); end
      total++; if (id_valid !== e_valid) begin bad++; $display("FAIL stall_valid c%0d got=%b exp=%b", i, id_valid, e_valid); end
      if (e_valid) begin
        total++; if (id_pc !== e_pc || id_instr !== e_instr) begin bad++; $display("FAIL stall_head c%0d got=%h/%h exp=%h/%h", i, id_pc, id_instr, e_pc, e_instr); end
      end
    end
  endtask

  task automatic test_redirect_full();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, i == 2, 32'h0000_0101, i > 2);
      total++; if (imem_req !== e_req) begin bad++; $display("FAIL redir_req c%0d got=%b exp=%b", i, imem_req, e_req); end
      total++; if (imem_addr !== e_addr) begin bad++; $display("FAIL redir_addr c%0d got=%h exp=%h", i, imem_addr, e_addr); end
      total++; if (id_valid !== e_valid) begin bad++; $display("FAIL redir_valid c%0d got=%b exp=%b", i, id_valid, e_valid); end
      if (e_valid) begin
        total++; if (id_pc !== e_pc || id_instr !== e_instr) begin bad++; $display("FAIL redir_head c%0d got=%h/%h exp=%h/%h", i, id_pc, id_instr, e_pc, e_instr); end
      end
    end
  endtask

  task automatic test_redirect_pop();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, i == 3, 32'h0000_2000, 1'b1);
      total++; if (id_valid !== e_valid) begin bad++; $display("FAIL rpop_valid c%0d got=%b exp=%b", i, id_valid, e_valid); end
      total++; if (imem_req !== e_req) begin bad++; $display("FAIL rpop_req c%0d got=%b exp=%b", i, imem_req, e_req); end
      if (e_valid) begin
        total++; if (id_pc !== e_pc) begin bad++; $display("FAIL rpop_pc c%0d got=%h exp=%h", i, id_pc, e_pc); end
      end
`ifdef IFETCH_PERF_CNT_EN
      total++; if (fetch_count !== e_cnt) begin bad++; $display("FAIL rpop_count c%0d got=%0d exp=%0d", i, fetch_count, e_cnt); end
`endif
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, i == 0, 32'hFFFF_FFF8, 1'b1);
      total++; if (imem_addr !== e_addr) begin bad++; $display("FAIL wrap_addr c%0d got=%h exp=%h", i, imem_addr, e_addr); end
      total++; if (id_valid !== e_valid) begin bad++; $display("FAIL wrap_valid c%0d got=%b exp=%b", i, id_valid, e_valid); end
      if (e_valid) begin
        total++; if (id_pc !== e_pc || id_instr !== e_instr) begin bad++; $display("FAIL wrap_head c%0d got=%h/%h exp=%h/%h", i, id_pc, id_instr, e_pc, e_instr); end
      end
    end
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 10; i++) begin
      cyc(i == 4, 1'b0, 32'h0, i != 2);
      total++; if (imem_req !== e_req) begin bad++; $display("FAIL mrst_req c%0d got=%b exp=%b", i, imem_req, e_req); end
      total++; if (imem_addr !== e_addr) begin bad++; $display("FAIL mrst_addr c%0d got=%h exp=%h", i, imem_addr, e_addr); end
      total++; if (id_valid !== e_valid) begin bad++; $display("FAIL mrst_valid c%0d got=%b exp=%b", i, id_valid, e_valid); end
      if (i == 5) begin
        total++; if (id_instr !== 32'h0000_0013) begin bad++; $display("FAIL mrst_instr got=%h exp=00000013", id_instr); end
      end
      if (e_valid) begin
        total++; if (id_pc !== e_pc || id_instr !== e_instr) begin bad++; $display("FAIL mrst_head c%0d got=%h/%h exp=%h/%h", i, id_pc, id_instr, e_pc, e_instr); end
      end
    end
  endtask

  task automatic test_random();
    logic r, rd, rdy;
    logic [31:0] rpc;
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 79) == 0);
      rd  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rpc = $urandom;
      cyc(r, rd, rpc, rdy);
      total++; if (imem_req !== e_req) begin bad++; $display("FAIL rand_req c%0d got=%b exp=%b", i, imem_req, e_req); end
      total++; if (imem_addr !== e_addr) begin bad++; $display("FAIL rand_addr c%0d got=%h exp=%h", i, imem_addr, e_addr); end
      total++; if (id_valid !== e_valid) begin bad++; $display("FAIL rand_valid c%0d got=%b exp=%b", i, id_valid, e_valid); end
      if (e_valid) begin
        total++; if (id_pc !== e_pc || id_instr !== e_instr) begin bad++; $display("FAIL rand_head c%0d got=%h/%h exp=%h/%h", i, id_pc, id_instr, e_pc, e_instr); end
      end
`ifdef IFETCH_PERF_CNT_EN
      total++; if (fetch_count !== e_cnt) begin bad++; $display("FAIL rand_count c%0d got=%0d exp=%0d", i, fetch_count, e_cnt); end
`endif
    end
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    m_q.delete(); m_infl = 1'b0; m_infl_pc = 32'h0; m_pc = RESET_PC; m_cnt = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_redirect_pop();
    test_wrap();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch front end of the multi-cycle pipelined RV32 core. It owns the program counter, issues word reads to the synchronous instruction memory, and buffers returned instructions in a small queue. Instructions are presented with their PCs to the decode stage through a valid/ready handshake. Branch and jump redirects from execute flush the queue and restart fetch at the new target.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- FQ_DEPTH, 2, fetch-queue entries; power of two, ≥2

- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state at the next rising edge
- imem_req  out  1  read request to instruction memory this cycle
- imem_addr  out  32  word-aligned read address, equal to the PC register
- imem_rdata  in  32  read data; valid exactly one cycle after an imem_req cycle (fixed latency, memory never stalls)
- redirect  in  1  flush request from execute
- redirect_pc  in  32  new fetch target; bits [1:0] ignored and treated as 00
- id_valid  out  1  queue head holds a valid instruction
- id_instr  out  32  head instruction
- id_pc  out  32  PC of head instruction
- id_ready  in  1  decode accepts head this cycle
- fetch_count  out  32  present only with IFETCH_PERF_CNT_EN

## Operation
- State: pc (32b), circular queue of FQ_DEPTH {instr, pc} entries, rd/wr pointers, count (0..FQ_DEPTH), inflight flag plus its request PC.
- pop = id_valid && id_ready; push = inflight && !redirect.
- imem_req = !reset && !redirect && (count + inflight − pop < FQ_DEPTH); a pop frees a credit in the same cycle.
- On imem_req: pc ← pc + 4 (modulo 2^32, 0xFFFF_FFFC wraps to 0); inflight ← 1 with request PC saved; else inflight ← 0.
- Push writes {imem_rdata, saved PC} at wr pointer; push and pop in the same cycle keep count unchanged. Pointers wrap at FQ_DEPTH.
- id_valid = (count != 0) && !redirect; id_instr/id_pc come from the registered head entry, with no bypass of imem_rdata.
- Stall: while id_valid && !id_ready, id_instr/id_pc stay stable and fetch continues until credits are exhausted.
- Redirect (priority over pop, push and request): count ← 0, pointers ← 0, the data arriving this cycle is dropped, pc ← {redirect_pc[31:2], 2'b00}, inflight ← 0.
- Reset: pc ← RESET_PC, count/pointers/inflight ← 0, entries ← {32'h0000_0013, 32'h0}. While reset is high: imem_req = 0, id_valid = 0. Reset overrides redirect. Reset asserted mid-stream discards queued and in-flight data.

## Timing
- Request in cycle N → data registered at end of N+1 → id_valid in N+2 (2-cycle fetch latency).
- First cycle with reset low: imem_req = 1, imem_addr = RESET_PC; first id_valid two cycles later.
- Sustained throughput is 1 instruction/cycle with id_ready held high and FQ_DEPTH ≥ 2.
- Redirect in cycle N: id_valid = 0 and imem_req = 0 in N. First request to the target in N+1, id_valid = 0 through N+2, target instruction presented in N+3.
- Back-to-back redirects: the last one wins, and each restarts the N+3 timing.

## Configuration
- IFETCH_PERF_CNT_EN defined: fetch_count port exists. It is a 32-bit counter of accepted pops, reset to 0, wraps at 2^32, and is not cleared by redirect.
- Not defined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset then release with RESET_PC = 0 and id_ready = 1 → imem_addr 0, 4, 8… on consecutive cycles; id_pc 0 two cycles after the first request, then one new instruction per cycle.
- Hold id_ready = 0 for 6 cycles → count saturates at FQ_DEPTH, imem_req drops, id_instr/id_pc remain stable. Raising id_ready → no lost or duplicated PCs.
- Redirect to 0x0000_0101 while the queue is full and a read is in flight → imem_addr 0x100 next cycle, id_pc 0x100 three cycles after redirect, stale instructions never presented.
- Redirect in the same cycle as id_ready = 1 with a valid head → no pop; with IFETCH_PERF_CNT_EN, fetch_count unchanged.
- Redirect to 0xFFFF_FFF8 → fetched PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert reset mid-stream for 1 cycle → next cycle id_valid = 0, imem_addr = RESET_PC, id_instr = 32'h0000_0013.
